// File: rtl/proc_ctrl_fsm_p_if.sv
// Control bus between the processor controller and its datapath.
// The master side is the controller: it samples the instruction and status,
// and it drives every PC, IR, memory, register-file and ALU control line.
interface proc_ctrl_fsm_p_if #(
  parameter int IR_W    = 16,
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4,
  parameter int ALU_W   = 3
);
  logic [IR_W-1:0]    IR;
  logic               RF_Ra_zero;
  logic               Resume;
  logic               PC_clr;
  logic               PC_up;
  logic               PC_ld;
  logic [DADDR_W-1:0] PC_off;
  logic               IR_Ld;
  logic [DADDR_W-1:0] D_addr;
  logic               D_wr;
  logic [1:0]         RF_s;
  logic [DADDR_W-1:0] Imm;
  logic [RADDR_W-1:0] RF_W_addr;
  logic               RF_W_en;
  logic [RADDR_W-1:0] RF_Ra_addr;
  logic [RADDR_W-1:0] RF_Rb_addr;
  logic [ALU_W-1:0]   Alu_s0;
  logic               Illegal;
  logic               Halted;
  logic [3:0]         OutState;

  modport master (
    input  IR, RF_Ra_zero, Resume,
    output PC_clr, PC_up, PC_ld, PC_off, IR_Ld, D_addr, D_wr, RF_s, Imm,
           RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0, Illegal,
           Halted, OutState
  );

  modport slave (
    output IR, RF_Ra_zero, Resume,
    input  PC_clr, PC_up, PC_ld, PC_off, IR_Ld, D_addr, D_wr, RF_s, Imm,
           RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0, Illegal,
           Halted, OutState
  );
endinterface

// File: rtl/proc_ctrl_fsm_p.sv
// Second-generation controller FSM for the programmable processor datapath.
// Decodes the instruction register and drives the datapath control lines.
//
// state    | enc | meaning
// INIT     |  0  | clear PC, entered on reset or an unused encoding
// FETCH    |  1  | load IR, increment PC
// DECODE   |  2  | dispatch on opcode, flag unknown opcodes, arm load timer
// NOOP     |  3  | idle for one cycle
// LOAD_A   |  4  | present data address, wait MEM_LAT cycles for read data
// LOAD_B   |  5  | write memory read data into the register file
// STORE    |  6  | write register A to data memory
// ALU      |  7  | Ra op Rb -> Rw (op 3 add, op 4 sub)
// LDI      |  8  | write zero-extended immediate into Rw
// HALT     |  9  | park until Resume
// JPZ      | 10  | add signed offset to PC when register A is zero
module proc_ctrl_fsm_p #(
  parameter int IR_W    = 16,
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4,
  parameter int ALU_W   = 3,
  parameter int MEM_LAT = 1
) (
  input logic                 Clk,
  input logic                 Rst,
  proc_ctrl_fsm_p_if.master   bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ALU    = 4'd7,
    S_LDI    = 4'd8,
    S_HALT   = 4'd9,
    S_JPZ    = 4'd10
  } state_t;

  // Four bits comfortably holds MEM_LAT-1 for the supported 1..8 range.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       opcode;

  assign opcode = bus.IR[IR_W-1 -: 4];

  // State and load-latency timer registers; reset is asynchronous.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the timer is armed in DECODE and counts down in LOAD_A.
  always_comb begin
    state_d = S_INIT;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        cnt_d = LAT_LOAD;
        case (opcode)
          4'd0:    state_d = S_NOOP;
          4'd1:    state_d = S_STORE;
          4'd2:    state_d = S_LOAD_A;
          4'd3:    state_d = S_ALU;
          4'd4:    state_d = S_ALU;
          4'd5:    state_d = S_HALT;
          4'd6:    state_d = S_LDI;
          4'd7:    state_d = S_JPZ;
          default: state_d = S_FETCH;
        endcase
      end
      S_LOAD_A: begin
        if (cnt_q == '0) begin
          state_d = S_LOAD_B;
        end else begin
          state_d = S_LOAD_A;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_NOOP, S_LOAD_B, S_STORE, S_ALU, S_LDI, S_JPZ: state_d = S_FETCH;
      S_HALT:   state_d = bus.Resume ? S_FETCH : S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Output decode from the current state; instruction fields come straight from IR.
  always_comb begin
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.PC_ld      = 1'b0;
    bus.PC_off     = '0;
    bus.IR_Ld      = 1'b0;
    bus.D_addr     = '0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 2'd0;
    bus.Imm        = '0;
    bus.RF_W_addr  = '0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.Alu_s0     = '0;
    bus.Illegal    = 1'b0;
    bus.Halted     = 1'b0;
    case (state_q)
      S_INIT:   bus.PC_clr = 1'b1;
      S_FETCH: begin
        bus.IR_Ld = 1'b1;
        bus.PC_up = 1'b1;
      end
      S_DECODE: bus.Illegal = (opcode > 4'd7);
      S_LOAD_A: begin
        bus.D_addr    = bus.IR[RADDR_W +: DADDR_W];
        bus.RF_s      = 2'd1;
        bus.RF_W_addr = bus.IR[RADDR_W-1:0];
      end
      S_LOAD_B: begin
        bus.D_addr    = bus.IR[RADDR_W +: DADDR_W];
        bus.RF_s      = 2'd1;
        bus.RF_W_addr = bus.IR[RADDR_W-1:0];
        bus.RF_W_en   = 1'b1;
      end
      S_STORE: begin
        bus.D_addr     = bus.IR[DADDR_W-1:0];
        bus.RF_Ra_addr = bus.IR[DADDR_W +: RADDR_W];
        bus.D_wr       = 1'b1;
      end
      S_ALU: begin
        bus.RF_Ra_addr = bus.IR[2*RADDR_W +: RADDR_W];
        bus.RF_Rb_addr = bus.IR[RADDR_W +: RADDR_W];
        bus.RF_W_addr  = bus.IR[RADDR_W-1:0];
        bus.RF_W_en    = 1'b1;
        bus.Alu_s0     = (opcode == 4'd3) ? ALU_W'(1) : ALU_W'(2);
      end
      S_LDI: begin
        bus.Imm       = bus.IR[RADDR_W +: DADDR_W];
        bus.RF_s      = 2'd2;
        bus.RF_W_addr = bus.IR[RADDR_W-1:0];
        bus.RF_W_en   = 1'b1;
      end
      S_JPZ: begin
        bus.RF_Ra_addr = bus.IR[DADDR_W +: RADDR_W];
        bus.PC_off     = bus.IR[DADDR_W-1:0];
        bus.PC_ld      = bus.RF_Ra_zero;
      end
      S_HALT:   bus.Halted = 1'b1;
      default:  ;
    endcase
  end

  assign bus.OutState = state_q;

endmodule
